// File: rtl/softmax_pkg.sv
// Shared constants, FSM state encoding and width helper for the softmax sampler.
package softmax_pkg;

  localparam int LOGIT_W = 16;
  localparam int EXP_W   = 40;
  localparam int RAND_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_SUM_DRAIN,
    ST_THRESH,
    ST_SCAN,
    ST_SCAN_DRAIN,
    ST_DONE
  } state_e;

  // Accumulator width: one exp result per logit, so log2(N) guard bits suffice.
  function automatic int sum_width(input int addr_w);
    return EXP_W + addr_w;
  endfunction

endpackage

// File: rtl/softmax_accum.sv
// Sum/cumulative accumulators, threshold multiply and first-hit index capture.
module softmax_accum import softmax_pkg::*; #(
  parameter int N_LOGITS = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              scan_i,
  input  logic              valid_i,
  input  logic              thr_load_i,
  input  logic              finalize_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [RAND_W-1:0] rand_i,
  output logic [ADDR_W-1:0] sel_index_o
);

  localparam int SUM_W = sum_width(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_LOGITS - 1);

  logic [SUM_W-1:0]        sum_q, cum_q, thr_q;
  logic [SUM_W-1:0]        sum_d, cum_d, thr_d;
  logic [SUM_W+RAND_W-1:0] prod;
  logic                    found_q;
  logic                    hit;
  logic [ADDR_W-1:0]       sel_q;

  assign sum_d = sum_q + SUM_W'(exp_i);
  assign cum_d = cum_q + SUM_W'(exp_i);

  // Full-width product so the >>RAND_W keeps thr strictly below sum.
  assign prod  = {{RAND_W{1'b0}}, sum_q} * {{SUM_W{1'b0}}, rand_i};
  assign thr_d = SUM_W'(prod >> RAND_W);

  // First result in the scan pass whose running total strictly exceeds thr.
  assign hit = valid_i && scan_i && !found_q && (cum_d > thr_q);

  assign sel_index_o = sel_q;

  // Accumulator, threshold and selection registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cum_q   <= '0;
      thr_q   <= '0;
      found_q <= 1'b0;
      sel_q   <= '0;
    end else if (clear_i) begin
      sum_q   <= '0;
      cum_q   <= '0;
      found_q <= 1'b0;
    end else begin
      if (valid_i && !scan_i) sum_q <= sum_d;
      if (valid_i && scan_i)  cum_q <= cum_d;
      if (thr_load_i)         thr_q <= thr_d;
      if (hit) begin
        found_q <= 1'b1;
        sel_q   <= idx_i;
      end else if (finalize_i && !found_q) begin
        sel_q   <= LAST_IDX;
      end
    end
  end

endmodule

// File: rtl/softmax_sampler_ctrl.sv
// Two-pass softmax sampler controller driving the shared exp unit.
// Optional temperature scaling is enabled by defining SOFTMAX_TEMP_EN.
module softmax_sampler_ctrl import softmax_pkg::*; #(
  parameter int N_LOGITS = 128,
  parameter int ADDR_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RAND_W-1:0]  rand_in,
`ifdef SOFTMAX_TEMP_EN
  input  logic [2:0]         temp_shift,
`endif
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  sel_index,
  output logic [ADDR_W-1:0]  logit_addr,
  input  logic [LOGIT_W-1:0] logit_data,
  output logic               exp_en,
  output logic [LOGIT_W-1:0] exp_in,
  input  logic [EXP_W-1:0]   exp_out,
  input  logic               exp_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_LOGITS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic [RAND_W-1:0] rand_lat_q, rand_lat_d;
  logic              clear, thr_load, finalize;
  logic              addr_valid, scan_pass;

  // Address/valid delay line: d1 aligns with exp_en, d2 with exp_out.
  logic              exp_en_q, res_valid_q;
  logic [ADDR_W-1:0] addr_d1_q, addr_d2_q;

`ifdef SOFTMAX_TEMP_EN
  logic [2:0] temp_lat_q;

  // Temperature shift is captured together with the random word.
  always_ff @(posedge clk) begin
    if (rst)                                temp_lat_q <= '0;
    else if (state_q == ST_IDLE && start)   temp_lat_q <= temp_shift;
  end

  assign exp_in = exp_en_q ? LOGIT_W'($signed(logit_data) >>> temp_lat_q) : '0;
`else
  assign exp_in = exp_en_q ? logit_data : '0;
`endif

  assign addr_valid = (state_q == ST_SUM) || (state_q == ST_SCAN);
  assign scan_pass  = (state_q == ST_SCAN) || (state_q == ST_SCAN_DRAIN);
  assign logit_addr = addr_q;
  assign exp_en     = exp_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

  // State, address counter, drain counter and latched random word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      rand_lat_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      rand_lat_q <= rand_lat_d;
    end
  end

  // Next-state logic and per-state control strobes.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    rand_lat_d = rand_lat_q;
    clear      = 1'b0;
    thr_load   = 1'b0;
    finalize   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SUM;
          addr_d     = '0;
          rand_lat_d = rand_in;
          clear      = 1'b1;
        end
      end
      ST_SUM, ST_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          drain_d = 1'b0;
          state_d = (state_q == ST_SUM) ? ST_SUM_DRAIN : ST_SCAN_DRAIN;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      ST_SUM_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_THRESH;
      end
      ST_THRESH: begin
        thr_load = 1'b1;
        state_d  = ST_SCAN;
      end
      ST_SCAN_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          finalize = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Delay the address-valid and address to line up with RAM data and exp results.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      addr_d1_q   <= '0;
      addr_d2_q   <= '0;
    end else begin
      exp_en_q    <= addr_valid;
      res_valid_q <= exp_en_q;
      addr_d1_q   <= addr_q;
      addr_d2_q   <= addr_d1_q;
    end
  end

  softmax_accum #(
    .N_LOGITS (N_LOGITS),
    .ADDR_W   (ADDR_W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .scan_i      (scan_pass),
    .valid_i     (exp_valid && res_valid_q),
    .thr_load_i  (thr_load),
    .finalize_i  (finalize),
    .exp_i       (exp_out),
    .idx_i       (addr_d2_q),
    .rand_i      (rand_lat_q),
    .sel_index_o (sel_index)
  );

endmodule

// File: tb/tb_softmax_sampler_ctrl.sv
// Directed bench for softmax_sampler_ctrl with N_LOGITS=4, a 1-cycle RAM and a
// table-lookup exp stub. Define SOFTMAX_TEMP_EN to also cover temperature scaling.
module tb_softmax_sampler_ctrl;

  localparam int N = 4;
  localparam int AW = 2;
  localparam int LATENCY = 2 * N + 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rand_in;
`ifdef SOFTMAX_TEMP_EN
  logic [2:0]  temp_shift;
`endif
  logic        busy, done;
  logic [AW-1:0] sel_index, logit_addr;
  logic [15:0] logit_data;
  logic        exp_en;
  logic [15:0] exp_in;
  logic [39:0] exp_out;
  logic        exp_valid;

  logic [15:0] ram [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] logit [N];
    logic [15:0] rnd;
    logic [2:0]  ts;
    int          sel;
  } vec_t;

  vec_t vecs [5];
  int   n_vecs;

  always #5 clk = ~clk;

  softmax_sampler_ctrl #(.N_LOGITS(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rand_in    (rand_in),
`ifdef SOFTMAX_TEMP_EN
    .temp_shift (temp_shift),
`endif
    .busy       (busy),
    .done       (done),
    .sel_index  (sel_index),
    .logit_addr (logit_addr),
    .logit_data (logit_data),
    .exp_en     (exp_en),
    .exp_in     (exp_in),
    .exp_out    (exp_out),
    .exp_valid  (exp_valid)
  );

  // exp stub: negative -> 1, 10.0 -> 36315, 1.25 -> 4, anything else -> 2.
  function automatic logic [39:0] exp_model(input logic [15:0] x);
    if (x[15])          return 40'd1;
    if (x == 16'h2800)  return 40'd36315;
    if (x == 16'h0500)  return 40'd4;
    return 40'd2;
  endfunction

  always @(posedge clk) begin
    logit_data <= ram[logit_addr];
    exp_valid  <= exp_en;
    exp_out    <= exp_en ? exp_model(exp_in) : 40'd0;
  end

  task automatic check(input string name, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic set_vec(input int i, input string nm, input logic [15:0] l0,
                         input logic [15:0] l1, input logic [15:0] l2,
                         input logic [15:0] l3, input logic [15:0] r,
                         input logic [2:0] ts, input int sel);
    vecs[i].name     = nm;
    vecs[i].logit[0] = l0;
    vecs[i].logit[1] = l1;
    vecs[i].logit[2] = l2;
    vecs[i].logit[3] = l3;
    vecs[i].rnd      = r;
    vecs[i].ts       = ts;
    vecs[i].sel      = sel;
  endtask

  // One full draw; inject>0 pulses a stray start (rand 0) at that cycle.
  task automatic run_draw(input int vi, input int inject);
    int cyc;
    int en_cnt;
    int extra_done;
    for (int k = 0; k < N; k++) ram[k] = vecs[vi].logit[k];
    @(negedge clk);
    start   = 1'b1;
    rand_in = vecs[vi].rnd;
`ifdef SOFTMAX_TEMP_EN
    temp_shift = vecs[vi].ts;
`endif
    cyc    = 0;
    en_cnt = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject != 0 && cyc == inject) begin
        start   = 1'b1;
        rand_in = 16'h0000;
      end
      if (exp_en) en_cnt++;
      if (cyc == 1) check({vecs[vi].name, "_busy"}, busy, 1);
      if (done) break;
    end
    start = 1'b0;
    check({vecs[vi].name, "_latency"}, cyc, LATENCY);
    check({vecs[vi].name, "_sel"}, sel_index, vecs[vi].sel);
    check({vecs[vi].name, "_exp_en_cycles"}, en_cnt, 2 * N);
    @(negedge clk);
    check({vecs[vi].name, "_idle_busy"}, busy, 0);
    extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) extra_done++;
      @(negedge clk);
    end
    check({vecs[vi].name, "_single_done"}, extra_done, 0);
    check({vecs[vi].name, "_sel_held"}, sel_index, vecs[vi].sel);
  endtask

  initial begin
    set_vec(0, "all0_r0",    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
    set_vec(1, "all0_rmax",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 3'd0, 3);
    set_vec(2, "peak2_rhalf",16'h0000, 16'h0000, 16'h2800, 16'h0000, 16'h8000, 3'd0, 2);
    set_vec(3, "neg_strict", 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h4000, 3'd0, 1);
    n_vecs = 4;
`ifdef SOFTMAX_TEMP_EN
    set_vec(4, "temp3",      16'h0000, 16'h0000, 16'h2800, 16'h0000, 16'h8000, 3'd3, 2);
    n_vecs = 5;
    temp_shift = 3'd0;
`endif
    for (int k = 0; k < N; k++) ram[k] = 16'h0000;

    rst     = 1'b1;
    start   = 1'b0;
    rand_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy",       busy, 0);
    check("rst_done",       done, 0);
    check("rst_sel_index",  sel_index, 0);
    check("rst_logit_addr", logit_addr, 0);
    check("rst_exp_en",     exp_en, 0);
    check("rst_exp_in",     exp_in, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < n_vecs; i++) run_draw(i, 0);

    // Stray start during SCAN must not relatch rand (rand 0 would pick index 0).
    vecs[1].name = "scan_restart";
    run_draw(1, 9);

    // Reset in the middle of the SUM pass, then a clean draw.
    for (int k = 0; k < N; k++) ram[k] = vecs[1].logit[k];
    @(negedge clk);
    start   = 1'b1;
    rand_in = vecs[1].rnd;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_exp_en", exp_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   busy, 0);
    check("midrst_exp_en", exp_en, 0);
    check("midrst_exp_in", exp_in, 0);
    check("midrst_sel",    sel_index, 0);
    rst = 1'b0;
    @(negedge clk);
    vecs[2].name = "after_rst";
    run_draw(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/softmax_sampler_ctrl.md
# softmax_sampler_ctrl

Sequences the shared `exp` lookup unit over a stored vector of logits to draw one index from the softmax distribution. Pass 1 streams every logit through `exp` and accumulates the sum. A threshold is then formed from a latched random word. Pass 2 re-streams the logits through `exp` and selects the first index whose running cumulative sum exceeds the threshold. The block sits between the output-layer logit RAM and the note-selection logic, and is the only master of the `exp` instance.

## Interface
Parameters:
- `N_LOGITS`, 128: number of logits per draw (≥2).
- `ADDR_W`, 7: logit address width, equal to clog2(N_LOGITS).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a draw; ignored unless `busy`=0.
- `rand_in`  in  16  unsigned random word, latched on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `sel_index` is valid in this cycle and held afterwards.
- `sel_index`  out  ADDR_W  selected logit index.
- `logit_addr`  out  ADDR_W  logit RAM read address; the RAM has a fixed 1-cycle read latency.
- `logit_data`  in  16  signed Q5.10 logit returned by the RAM.
- `exp_en`  out  1  drives `exp.en`.
- `exp_in`  out  16  drives `exp.in`.
- `exp_out`  in  40  `exp.out`; valid 1 cycle after `exp_en`.
- `exp_valid`  in  1  `exp.valid`; qualifies accumulation.

## Operation
- FSM states: IDLE → SUM → SUM_DRAIN → THRESH → SCAN → SCAN_DRAIN → DONE → IDLE.
- IDLE:
  - On `start`, latch `rand_in`, clear the address counter, `sum` and `cum`, and go to SUM.
- SUM:
  - Issue `logit_addr` = 0..N_LOGITS-1, one per cycle.
  - `exp_en` and `exp_in` are the address-valid and RAM data, delayed 1 cycle.
  - After the last address, go to SUM_DRAIN.
- SUM_DRAIN: 2 cycles, during which the last two `exp_valid` results are added to `sum`.
- Sum width is SUM_W = 40+ADDR_W. The sum cannot overflow.
- THRESH (1 cycle): `thr` = (`sum` × `rand_lat`) >> 16, truncated to SUM_W bits.
  - This guarantees `thr` < `sum`.
- SCAN:
  - Re-issue addresses 0..N_LOGITS-1 as in SUM.
  - On each `exp_valid`, `cum` ← `cum` + `exp_out`.
  - On the first result where the new `cum` > `thr` (strict compare), record the index of that result in `sel_index` and set `found`.
  - Later results still accumulate but never overwrite `sel_index`.
  - There is no early exit; latency is fixed.
- SCAN_DRAIN: 2 cycles.
  - If `found`=0 at the end, force `sel_index` = N_LOGITS-1. This is a safety default that cannot occur because every exp result is ≥1.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` while `busy` is dropped and has no effect.
- `rst` at any time, including mid-pass:
  - FSM returns to IDLE.
  - In-flight `exp_valid` results are ignored.
  - Registers are cleared.
- Reset values: `busy`=0, `done`=0, `sel_index`=0, `logit_addr`=0, `exp_en`=0, `exp_in`=0. Internal `sum`, `cum`, `thr`, `rand_lat` and `found` are all 0.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..N: SUM. Address k is driven in cycle k+1. `exp_en`=1 in cycle k+2. `exp_out` is valid in cycle k+3.
- Cycles N+1..N+2: SUM_DRAIN. The final addition to `sum` lands at the end of cycle N+2.
- Cycle N+3: THRESH.
- Cycles N+4..2N+3: SCAN. Cycles 2N+4..2N+5: SCAN_DRAIN.
- Cycle 2N+6: `done`=1. Total latency is 2·N_LOGITS+6 cycles from `start`.
- `exp_en` is 0 in every cycle other than the 2·N_LOGITS data cycles.
- A new `start` is accepted at the earliest in cycle 2N+7.

## Configuration
- `SOFTMAX_TEMP_EN` defined:
  - Adds input port `temp_shift` (3 bits), latched with `rand_in`.
  - `exp_in` = `logit_data` >>> `temp_shift` (arithmetic shift), which flattens the distribution.
- `SOFTMAX_TEMP_EN` undefined: the port is absent and `exp_in` = `logit_data` unchanged.

## Structure
- Package `softmax_pkg` holds:
  - Constants `LOGIT_W`=16, `EXP_W`=40, `RAND_W`=16.
  - The FSM state enum.
  - The function computing SUM_W from ADDR_W.
- One sub-module, `softmax_accum`:
  - Holds the `sum`/`cum` accumulator, threshold multiply, strict compare and first-hit capture.
  - Controlled by pass-select, clear and valid inputs.
- Address and valid pipeline delay registers stay in the top level.
- The `exp` instance lives outside this block and connects through the ports above.

## Test plan
Bench uses N_LOGITS=4, ADDR_W=2, a behavioural `exp` model, and a 1-cycle RAM.
- Logits all 0 (exp=2), `rand_in`=0 → `thr`=0, so `sel_index`=0. `done` arrives exactly 14 cycles after `start`.
- Logits all 0, `rand_in`=0xFFFF → `thr`=7; `cum` runs 2,4,6,8 → `sel_index`=3.
- Logits {0,0,0x2800,0}, where logit[2] is 10.0 (exp 36315) → `sum`=36321. With `rand_in`=0x8000 → `thr`=18160 → `sel_index`=2.
- Logits all negative (exp=1), `rand_in`=0x4000 → `thr`=1. `cum`=1 is not > 1, so `sel_index`=1 (strict-compare check).
- Second `start` during SCAN is ignored, and `done` pulses once. `rst` asserted mid-SUM clears `busy`/`exp_en` next cycle, and a fresh `start` then completes normally.
- With `SOFTMAX_TEMP_EN`: `temp_shift`=3, logit[2]=0x2800 → `exp_in`=0x0500 (exp 4); others 0 → `sum`=10. `rand_in`=0x8000 → `thr`=5; `cum` runs 2,4,8 → `sel_index`=2.
